bus_timer_device: RTL and testbench
===================================

// Module: bus_timer_device
// PURPOSE
//  Memory-mapped timer peripheral; responder (target) on the CPU data bus (addr/we/re/data).
//  Decodes a 3-register window at BASE_ADDR.
//  Counts clock ticks, wraps at a programmable limit and raises a level interrupt.
//  Answers the CPU interrupt-acknowledge (inta) by driving its device number on idn.
// PARAMETERS
//  DBITS      32            bus/data width
//  BASE_ADDR  32'hF0000020  byte address of TCNT; TLIM=+4, TCTL=+8 (word aligned)
//  DEV_ID     32'h1         value driven on idn during acknowledge
//  CLK_DIV    32'd50000     clk cycles per tick (used only with TIMER_PRESCALE_EN)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  reset       in   1      asynchronous, active-high reset
//  memAddrBus  in   DBITS  byte address from CPU
//  dataBusIn   in   DBITS  write data from CPU (CPU's dataBusOut)
//  weBus       in   1      write strobe, one cycle per store
//  reBus       in   1      read strobe, one cycle per load
//  dataBusOut  out  DBITS  read data to CPU; 0 when not selected (wired-OR bus)
//  intr        out  1      interrupt request, level
//  inta        in   1      interrupt acknowledge from CPU
//  idn         out  DBITS  DEV_ID while inta&&intr, else 0 (wired-OR)
// BEHAVIOUR
//  Reset: TCNT=0, TLIM=0, TCTL=0; intr=0, idn=0, dataBusOut=0.
//  Select: sel = reBus|weBus with memAddrBus[DBITS-1:4]==BASE_ADDR[DBITS-1:4], offset 0/4/8; offset C and
//   addresses outside the window: no effect, read 0.
//  Read: combinational, zero latency; dataBusOut = reg value while reBus&&sel, else 0.
//  Write: takes effect at the rising edge ending the weBus cycle; value visible to a read next cycle.
//  TCTL bits: [0] READY, [1] OVERRUN, [4] IE; other bits read 0, writes ignored.
//   READY/OVERRUN: write 0 clears, write 1 no effect (cannot set by software). IE: plain R/W.
//  Tick: every clk (macro off) or one cycle per CLK_DIV clk (macro on).
//  On tick, TLIM!=0: if TCNT==TLIM-1 -> TCNT=0, READY=1, and OVERRUN=1 if READY already 1;
//   else TCNT=TCNT+1. TLIM==0: counting stopped, TCNT holds.
//  TCNT>=TLIM (e.g. after TLIM shrinks): increments modulo 2^DBITS until equal to TLIM-1 (wrap at 2^DBITS).
//  Simultaneous events:
//   - SW write to TCNT + tick: write wins, tick lost.
//   - SW clear of READY/OVERRUN + wrap: hardware set wins (event never lost).
//   - SW write to TLIM + tick: compare uses old TLIM.
//  intr = READY & IE (registered state only, no combinational path from bus).
//   Stays high until software clears READY or IE; inta does not clear it.
//  idn = (inta && intr) ? DEV_ID : 0, combinational.
//  Reset mid-operation: all state incl. prescaler returns to reset values immediately.
// CONFIGURATION
//  TIMER_PRESCALE_EN defined: prescaler counts 0..CLK_DIV-1, tick pulses 1 cycle on wrap.
//   The prescaler is also cleared by any write to TCNT, so the next tick comes CLK_DIV cycles later.
//  TIMER_PRESCALE_EN undefined: tick=1 every cycle; CLK_DIV ignored, no prescaler logic.
// STRUCTURE
//  Package timer_pkg: register offsets (TCNT_OFS=0, TLIM_OFS=4, TCTL_OFS=8), TCTL bit indices
//   (READY_BIT, OVERRUN_BIT, IE_BIT), TCTL write mask.
//  Sub-module timer_prescaler (clk, reset, clr, tick), instantiated only under TIMER_PRESCALE_EN.
//  Top: address decode, register file, counter/compare, interrupt logic.
// TESTING
//  Reset with bus idle -> all reads return 0, intr=0, idn=0; read of BASE_ADDR+0xC -> 0.
//  Macro off, TLIM=3, IE=1 -> TCNT sequence 0,1,2,0; READY=1 and intr=1 on the edge TCNT 2->0.
//  Leave READY set through a second wrap -> TCTL reads 0x13.
//   Then write TCTL=0x10 -> reads 0x10, intr=0.
//  Wrap in same cycle as write TCTL=0x10 -> READY stays 1.
//   Write TCNT=7 in same cycle as tick -> TCNT reads 7.
//  intr=1, pulse inta -> idn=DEV_ID only during inta; reads at other addresses -> dataBusOut=0.
//  Macro on, CLK_DIV=4, TLIM=2 -> TCNT increments every 4 clk.
//   Assert reset mid-count -> TCNT=0, prescaler restarts.

Source files
------------

// File: rtl/timer_pkg.sv
// Register map, TCTL bit layout and offset decode shared by the timer peripheral.
`default_nettype none

package timer_pkg;

  localparam logic [3:0] TCNT_OFS = 4'h0;
  localparam logic [3:0] TLIM_OFS = 4'h4;
  localparam logic [3:0] TCTL_OFS = 4'h8;

  localparam int READY_BIT   = 0;
  localparam int OVERRUN_BIT = 1;
  localparam int IE_BIT      = 4;

  // Only these TCTL bits exist; everything else reads as zero.
  localparam logic [31:0] TCTL_WMASK = 32'h0000_0013;

  typedef enum logic [1:0] {
    REG_TCNT = 2'd0,
    REG_TLIM = 2'd1,
    REG_TCTL = 2'd2,
    REG_NONE = 2'd3
  } reg_sel_e;

  function automatic reg_sel_e decode_ofs(input logic [3:0] ofs);
    case (ofs)
      TCNT_OFS: decode_ofs = REG_TCNT;
      TLIM_OFS: decode_ofs = REG_TLIM;
      TCTL_OFS: decode_ofs = REG_TCTL;
      default:  decode_ofs = REG_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// Tick generator: counts 0..DIV-1 and pulses tick for one cycle on the last count.
`default_nettype none

module timer_prescaler #(
  parameter logic [31:0] DIV = 32'd50000,
  parameter int          W   = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 32'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_timer_device.sv
// Memory-mapped timer (TCNT/TLIM/TCTL) with level interrupt and acknowledge ID.
// Optional tick prescaler enabled by defining TIMER_PRESCALE_EN.
`default_nettype none

module bus_timer_device
  import timer_pkg::*;
#(
  parameter int          DBITS     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hF000_0020,
  parameter logic [31:0] DEV_ID    = 32'h0000_0001,
  parameter logic [31:0] CLK_DIV   = 32'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] memAddrBus,
  input  logic [DBITS-1:0] dataBusIn,
  input  logic             weBus,
  input  logic             reBus,
  output logic [DBITS-1:0] dataBusOut,
  output logic             intr,
  input  logic             inta,
  output logic [DBITS-1:0] idn
);

  logic [DBITS-1:0] tcnt;
  logic [DBITS-1:0] tlim;
  logic             ready;
  logic             overrun;
  logic             ie;

  logic             in_window;
  reg_sel_e         rsel;
  logic             sel;
  logic             wr_tcnt;
  logic             wr_tlim;
  logic             wr_tctl;
  logic             tick;
  logic             advance;
  logic             wrap;
  logic [DBITS-1:0] tctl_word;

  assign in_window = (memAddrBus[DBITS-1:4] == BASE_ADDR[DBITS-1:4]);
  assign rsel      = in_window ? decode_ofs(memAddrBus[3:0]) : REG_NONE;
  assign sel       = (reBus || weBus) && (rsel != REG_NONE);
  assign wr_tcnt   = weBus && sel && (rsel == REG_TCNT);
  assign wr_tlim   = weBus && sel && (rsel == REG_TLIM);
  assign wr_tctl   = weBus && sel && (rsel == REG_TCTL);

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(
    .DIV (CLK_DIV),
    .W   (DBITS)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (wr_tcnt),
    .tick  (tick)
  );
`else
  logic unused_clk_div;
  assign unused_clk_div = ^CLK_DIV;
  assign tick           = 1'b1;
`endif

  // A software write to TCNT swallows the tick; the compare always sees the current TLIM.
  assign advance = tick && (tlim != '0) && !wr_tcnt;
  assign wrap    = advance && (tcnt == tlim - DBITS'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt    <= '0;
      tlim    <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (wr_tcnt) begin
        tcnt <= dataBusIn;
      end else if (advance) begin
        tcnt <= wrap ? '0 : tcnt + DBITS'(1);
      end

      if (wr_tlim) begin
        tlim <= dataBusIn;
      end

      // Hardware set beats a simultaneous software clear so no wrap is lost.
      if (wrap) begin
        ready <= 1'b1;
      end else if (wr_tctl && !dataBusIn[READY_BIT]) begin
        ready <= 1'b0;
      end

      if (wrap && ready) begin
        overrun <= 1'b1;
      end else if (wr_tctl && !dataBusIn[OVERRUN_BIT]) begin
        overrun <= 1'b0;
      end

      if (wr_tctl) begin
        ie <= dataBusIn[IE_BIT];
      end
    end
  end

  always_comb begin
    tctl_word              = '0;
    tctl_word[READY_BIT]   = ready;
    tctl_word[OVERRUN_BIT] = overrun;
    tctl_word[IE_BIT]      = ie;
    tctl_word              = tctl_word & DBITS'(TCTL_WMASK);
  end

  always_comb begin
    dataBusOut = '0;
    if (reBus && sel) begin
      case (rsel)
        REG_TCNT: dataBusOut = tcnt;
        REG_TLIM: dataBusOut = tlim;
        REG_TCTL: dataBusOut = tctl_word;
        default:  dataBusOut = '0;
      endcase
    end
  end

  assign intr = ready && ie;
  assign idn  = (inta && intr) ? DBITS'(DEV_ID) : '0;

endmodule

`default_nettype wire

// File: tb/tb_bus_timer_device.sv
// Directed self-checking bench for bus_timer_device (both TIMER_PRESCALE_EN builds).
`default_nettype none

module tb_bus_timer_device;

  localparam logic [31:0] BASE   = 32'hF000_0020;
  localparam logic [31:0] A_TCNT = BASE + 32'h0;
  localparam logic [31:0] A_TLIM = BASE + 32'h4;
  localparam logic [31:0] A_TCTL = BASE + 32'h8;
  localparam logic [31:0] A_RSVD = BASE + 32'hC;
  localparam logic [31:0] A_OUT  = 32'hF000_0030;
  localparam logic [31:0] ID     = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAddrBus;
  logic [31:0] dataBusIn;
  logic        weBus;
  logic        reBus;
  logic [31:0] dataBusOut;
  logic        intr;
  logic        inta;
  logic [31:0] idn;

  int checks = 0;
  int fails  = 0;

  bus_timer_device #(
    .DBITS     (32),
    .BASE_ADDR (BASE),
    .DEV_ID    (ID),
    .CLK_DIV   (32'd4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memAddrBus (memAddrBus),
    .dataBusIn  (dataBusIn),
    .weBus      (weBus),
    .reBus      (reBus),
    .dataBusOut (dataBusOut),
    .intr       (intr),
    .inta       (inta),
    .idn        (idn)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", checks, fails);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Combinational read, no clock edge consumed.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memAddrBus = a;
    reBus      = 1'b1;
    #1;
    chk(tag, dataBusOut, exp);
    reBus      = 1'b0;
  endtask

  // Called between edges; the write commits on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memAddrBus = a;
    dataBusIn  = d;
    weBus      = 1'b1;
    @(negedge clk);
    weBus      = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    memAddrBus = '0;
    dataBusIn  = '0;
    weBus      = 1'b0;
    reBus      = 1'b0;
    inta       = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);

    rd("rst_tcnt", A_TCNT, 32'h0);
    rd("rst_tlim", A_TLIM, 32'h0);
    rd("rst_tctl", A_TCTL, 32'h0);
    rd("rst_rsvd", A_RSVD, 32'h0);
    chk("rst_intr", {31'h0, intr}, 32'h0);
    chk("rst_idn", idn, 32'h0);

`ifndef TIMER_PRESCALE_EN
    wr(A_TCTL, 32'h10);
    rd("ie_tctl", A_TCTL, 32'h10);
    chk("ie_intr", {31'h0, intr}, 32'h0);
    rd("stopped_tcnt", A_TCNT, 32'h0);

    wr(A_TLIM, 32'd3);
    rd("lim_tlim", A_TLIM, 32'd3);
    rd("seq0", A_TCNT, 32'd0);
    step(1);
    rd("seq1", A_TCNT, 32'd1);
    step(1);
    rd("seq2", A_TCNT, 32'd2);
    chk("seq2_intr", {31'h0, intr}, 32'h0);
    step(1);
    rd("seq3_wrap", A_TCNT, 32'd0);
    rd("wrap_tctl", A_TCTL, 32'h11);
    chk("wrap_intr", {31'h0, intr}, 32'h1);

    step(3);
    rd("wrap2_tcnt", A_TCNT, 32'd0);
    rd("overrun_tctl", A_TCTL, 32'h13);

    wr(A_TCTL, 32'h10);
    rd("clr_tctl", A_TCTL, 32'h10);
    chk("clr_intr", {31'h0, intr}, 32'h0);
    rd("clr_tcnt", A_TCNT, 32'd1);

    step(1);
    rd("pre_race_tcnt", A_TCNT, 32'd2);
    wr(A_TCTL, 32'h10);
    rd("race_tctl", A_TCTL, 32'h11);
    rd("race_tcnt", A_TCNT, 32'd0);
    chk("race_intr", {31'h0, intr}, 32'h1);

    wr(A_TCNT, 32'd7);
    rd("wrtick_tcnt", A_TCNT, 32'd7);
    step(1);
    rd("above_lim_tcnt", A_TCNT, 32'd8);

    chk("idn_idle", idn, 32'h0);
    inta = 1'b1;
    #1;
    chk("idn_ack", idn, ID);
    rd("out_of_window", A_OUT, 32'h0);
    rd("ack_rsvd", A_RSVD, 32'h0);
    step(1);
    chk("ack_keeps_intr", {31'h0, intr}, 32'h1);
    inta = 1'b0;
    #1;
    chk("idn_release", idn, 32'h0);
    memAddrBus = A_TCTL;
    reBus      = 1'b0;
    #1;
    chk("no_re_out", dataBusOut, 32'h0);

    wr(A_TCTL, 32'hFFFF_FFFF);
    rd("mask_tctl", A_TCTL, 32'h11);
    rd("mask_tcnt", A_TCNT, 32'd10);

    wr(A_TCNT, 32'd5);
    wr(A_TLIM, 32'd0);
    rd("oldlim_tcnt", A_TCNT, 32'd6);
    step(2);
    rd("stop_tcnt", A_TCNT, 32'd6);
    rd("stop_tlim", A_TLIM, 32'd0);

    reset = 1'b1;
    #1;
    rd("async_tcnt", A_TCNT, 32'd0);
    rd("async_tctl", A_TCTL, 32'h0);
    chk("async_intr", {31'h0, intr}, 32'h0);
    step(1);
    reset = 1'b0;
    step(1);
`else
    wr(A_TLIM, 32'd2);
    wr(A_TCNT, 32'd0);
    step(3);
    rd("ps_hold3", A_TCNT, 32'd0);
    step(1);
    rd("ps_tick1", A_TCNT, 32'd1);
    step(3);
    rd("ps_hold7", A_TCNT, 32'd1);
    step(1);
    rd("ps_wrap", A_TCNT, 32'd0);
    rd("ps_ready", A_TCTL, 32'h01);

    step(2);
    reset = 1'b1;
    #1;
    rd("ps_rst_tcnt", A_TCNT, 32'd0);
    rd("ps_rst_tctl", A_TCTL, 32'h0);
    step(1);
    reset = 1'b0;
    wr(A_TLIM, 32'd2);
    step(2);
    rd("ps_restart_hold", A_TCNT, 32'd0);
    step(1);
    rd("ps_restart_tick", A_TCNT, 32'd1);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

`default_nettype wire
